load_store_unit: RTL and testbench

Sits between `processor_core` and the data memory. Turns the core's single-cycle memory request into a registered, ready-handshaked bus transaction:
- generates byte enables and replicates store data;
- sign- or zero-extends load data;
- holds the core in `stall_i` until the access completes.

Misaligned or unsupported accesses are flagged and never reach memory.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_rdata_extend.sv | 40 ++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 size codes, LSU FSM states, helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    // funct3 size codes, shared with the instruction decoder
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        DRAIN
    } lsu_state_t;

    // Codes 3, 6 and 7 have no load/store meaning
    function automatic logic size_is_bad(input logic [2:0] size);
        return (size == 3'd3) || (size == 3'd6) || (size == 3'd7);
    endfunction

    // Alignment check for the legal sizes; bytes are always aligned
    function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            LDST_H, LDST_HU: mis = off[0];
            LDST_W:          mis = |off;
            default:         mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_rdata_extend.sv
// Selects the addressed byte/half of a bus read word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
module lsu_rdata_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select from the low address bits
    always_comb begin
        byte_sel = word_i[7:0];
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Extension by size code; anything else passes the whole word
    always_comb begin
        data_o = word_i;
        case (size_i)
            LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: data_o = {24'd0, byte_sel};
            LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Converts a single-cycle core memory request into a registered req/ready bus access.
// Latency: 3 cycles minimum (capture, wait-with-ready, retire), +1 per extra bus wait cycle.
// Backpressure: core held via core_stall_o until DONE; an abandoned access is drained to completion.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    lsu_state_t  state_q, state_d;

    logic        req_q, req_d;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q;

    logic        core_err;
    logic        capture;
    logic        rd_load;
    logic [31:0] rd_ext;

    // Illegal size or misalignment; such requests never leave IDLE
    always_comb begin
        core_err = core_req_i &
                   (size_is_bad(core_size_i) | size_misaligned(core_size_i, core_addr_i[1:0]));
    end

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        be_d = 4'b1111;
        wd_d = core_wd_i;
        case (core_size_i)
            LDST_B, LDST_BU: begin
                be_d = 4'b0001 << core_addr_i[1:0];
                wd_d = {4{core_wd_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be_d = core_addr_i[1] ? 4'b1100 : 4'b0011;
                wd_d = {2{core_wd_i[15:0]}};
            end
            default: begin
                be_d = 4'b1111;
                wd_d = core_wd_i;
            end
        endcase
    end

    // Next-state logic; the bus request is asserted while WAIT or DRAIN is occupied
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        rd_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i && !core_err) begin
                    capture = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Ready wins over a same-cycle request drop
                if (mem_ready_i) begin
                    rd_load = ~we_q;
                    state_d = DONE;
                end else if (!core_req_i) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d = (state_d == WAIT) || (state_d == DRAIN);
    end

    // State and bus request registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Capture registers drive the bus for the whole transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q   <= 1'b0;
            size_q <= 3'd0;
            off_q  <= 2'd0;
            addr_q <= 32'd0;
            be_q   <= 4'd0;
            wd_q   <= 32'd0;
        end else if (capture) begin
            we_q   <= core_we_i;
            size_q <= core_size_i;
            off_q  <= core_addr_i[1:0];
            addr_q <= {core_addr_i[31:2], 2'b00};
            be_q   <= be_d;
            wd_q   <= wd_d;
        end
    end

    lsu_rdata_extend u_rdata_extend (
        .size_i (size_q),
        .off_i  (off_q),
        .word_i (mem_rd_i),
        .data_o (rd_ext)
    );

    // Load result register; held until the next load completes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q <= 32'd0;
        end else if (rd_load) begin
            rd_q <= rd_ext;
        end
    end

    assign core_err_o   = core_err;
    assign core_stall_o = core_req_i & ~core_err & (state_q != DONE);
    assign core_rd_o    = rd_q;

    assign mem_req_o    = req_q;
    assign mem_we_o     = we_q;
    assign mem_be_o     = be_q;
    assign mem_addr_o   = addr_q;
    assign mem_wd_o     = wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected bus/core events, a monitor checks them.
// Latency: n/a.
// Backpressure: bench models the bus ready with a per-access wait count.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        core_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        mem_ready;

    load_store_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .core_err_o   (core_err),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } bus_exp_t;

    typedef struct {
        logic        is_load;
        logic [31:0] rd;
        int          stalls;
    } core_exp_t;

    bus_exp_t  bus_q[$];
    core_exp_t core_q[$];
    int        err_q[$];

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: pops and compares whenever the DUT completes a bus access, retires, or flags an error
    int        stall_cnt = 0;
    bus_exp_t  b_item;
    core_exp_t c_item;
    int        e_item;
    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
        end else begin
            if (!core_req) stall_cnt = 0;
            if (core_req && core_stall) stall_cnt++;
            if (mem_req && mem_ready) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_completion", 32'd1, 32'd0);
                end else begin
                    b_item = bus_q.pop_front();
                    chk("bus_we", {31'd0, mem_we}, {31'd0, b_item.we});
                    chk("bus_be", {28'd0, mem_be}, {28'd0, b_item.be});
                    chk("bus_addr", mem_addr, b_item.addr);
                    if (b_item.we) chk("bus_wd", mem_wd, b_item.wd);
                end
            end
            if (core_req && !core_stall && !core_err) begin
                if (core_q.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    c_item = core_q.pop_front();
                    chk("stall_cycles", stall_cnt, c_item.stalls);
                    if (c_item.is_load) chk("load_data", core_rd, c_item.rd);
                end
                stall_cnt = 0;
            end
            if (core_req && core_err) begin
                if (err_q.size() == 0) begin
                    chk("unexpected_err", 32'd1, 32'd0);
                end else begin
                    e_item = err_q.pop_front();
                    chk("err_no_stall", {31'd0, core_stall}, 32'd0);
                    chk("err_no_req", {31'd0, mem_req}, 32'd0);
                end
            end
        end
    end

    // One complete access; nwait = number of WAIT cycles, ready on the last one
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rword, input int nwait,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
        logic [31:0] a_al;
        a_al = {addr[31:2], 2'b00};
        bus_q.push_back('{we, ebe, a_al, ewd});
        core_q.push_back('{~we, erd, 1 + nwait});
        core_req  = 1'b1;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = wd;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= nwait; i++) begin
            mem_ready = (i == nwait);
            mem_rd    = (i == nwait) ? rword : 32'hBAD0BAD0;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(posedge clk); #1;
        core_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic err_case(input logic we, input logic [2:0] size, input logic [31:0] addr);
        err_q.push_back(1);
        core_req  = 1'b1;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = 32'h55AA55AA;
        @(negedge clk);
        chk("err_flag", {31'd0, core_err}, 32'd1);
        @(posedge clk); #1;
        chk("err_no_capture", {31'd0, mem_req}, 32'd0);
        core_req = 1'b0;
        @(posedge clk); #1;
        chk("err_still_idle", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        core_req  = 1'b0;
        core_we   = 1'b0;
        core_size = 3'd0;
        core_addr = 32'd0;
        core_wd   = 32'd0;
        mem_rd    = 32'd0;
        mem_ready = 1'b0;

        #2;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_core_rd", core_rd, 32'd0);
        chk("rst_stall", {31'd0, core_stall}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Stores: word with two WAIT cycles, then byte and half lanes
        access(1'b1, LDST_W, 32'h100, 32'hDEADBEEF, 32'h0, 2, 4'b1111, 32'hDEADBEEF, 32'h0);
        access(1'b1, LDST_B, 32'h103, 32'h000000A5, 32'h0, 1, 4'b1000, 32'hA5A5A5A5, 32'h0);
        access(1'b1, LDST_H, 32'h102, 32'h1234CAFE, 32'h0, 1, 4'b1100, 32'hCAFECAFE, 32'h0);
        access(1'b1, LDST_B, 32'h101, 32'h0000003C, 32'h0, 3, 4'b0010, 32'h3C3C3C3C, 32'h0);

        // Loads from the word 0x80FF7F01 at 0x200
        access(1'b0, LDST_B,  32'h203, 32'h0, 32'h80FF7F01, 1, 4'b1000, 32'h0, 32'hFFFFFF80);
        access(1'b0, LDST_BU, 32'h203, 32'h0, 32'h80FF7F01, 1, 4'b1000, 32'h0, 32'h00000080);
        access(1'b0, LDST_H,  32'h200, 32'h0, 32'h80FF7F01, 2, 4'b0011, 32'h0, 32'h00007F01);
        access(1'b0, LDST_W,  32'h200, 32'h0, 32'h80FF7F01, 1, 4'b1111, 32'h0, 32'h80FF7F01);
        access(1'b0, LDST_B,  32'h201, 32'h0, 32'h80FF7F01, 1, 4'b0010, 32'h0, 32'h0000007F);
        access(1'b0, LDST_H,  32'h202, 32'h0, 32'h80FF7F01, 1, 4'b1100, 32'h0, 32'hFFFF80FF);
        access(1'b0, LDST_HU, 32'h202, 32'h0, 32'h80FF7F01, 1, 4'b1100, 32'h0, 32'h000080FF);

        // Misaligned and unsupported requests
        err_case(1'b0, LDST_W, 32'h201);
        err_case(1'b0, LDST_H, 32'h203);
        err_case(1'b0, 3'd3,   32'h200);
        err_case(1'b1, 3'd6,   32'h200);
        err_case(1'b1, LDST_HU, 32'h101);

        // Abandoned load drains; a store issued during DRAIN is stalled, then captured
        bus_q.push_back('{1'b0, 4'b1111, 32'h300, 32'h0});
        bus_q.push_back('{1'b1, 4'b1111, 32'h104, 32'h11223344});
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_size = LDST_W;
        core_addr = 32'h300;
        @(posedge clk); #1;            // WAIT
        core_req = 1'b0;
        @(posedge clk); #1;            // DRAIN 1
        @(negedge clk);
        chk("drain_holds_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;            // DRAIN 2
        core_q.push_back('{1'b0, 32'h0, 4});
        core_req  = 1'b1;
        core_we   = 1'b1;
        core_size = LDST_W;
        core_addr = 32'h104;
        core_wd   = 32'h11223344;
        @(negedge clk);
        chk("drain_stalls_new_req", {31'd0, core_stall}, 32'd1);
        chk("drain_still_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;            // DRAIN 3 with ready
        mem_ready = 1'b1;
        mem_rd    = 32'h12345678;
        @(posedge clk); #1;            // IDLE, captures store
        mem_ready = 1'b0;
        chk("drain_rd_unchanged", core_rd, 32'h000080FF);
        @(posedge clk); #1;            // WAIT with ready
        mem_ready = 1'b1;
        @(posedge clk); #1;            // DONE
        mem_ready = 1'b0;
        @(posedge clk); #1;
        core_req = 1'b0;
        chk("store_keeps_rd", core_rd, 32'h000080FF);
        @(posedge clk); #1;

        // Reset asserted mid-WAIT clears bus outputs without a clock edge
        core_req  = 1'b1;
        core_we   = 1'b1;
        core_size = LDST_W;
        core_addr = 32'h108;
        core_wd   = 32'hCAFEF00D;
        @(posedge clk); #1;            // WAIT
        chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("arst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_mem_wd", mem_wd, 32'd0);
        chk("arst_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        chk("arst_stall_follows_req", {31'd0, core_stall}, 32'd1);
        @(posedge clk); #1;
        core_req = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", {31'd0, mem_req}, 32'd0);

        // Ready while idle is ignored
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("idle_ignores_ready", {31'd0, mem_req}, 32'd0);
        access(1'b0, LDST_BU, 32'h402, 32'h0, 32'h00C30000, 1, 4'b0100, 32'h0, 32'h000000C3);

        repeat (3) @(posedge clk);
        #1;
        chk("bus_queue_empty", bus_q.size(), 32'd0);
        chk("core_queue_empty", core_q.size(), 32'd0);
        chk("err_queue_empty", err_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
